// File: rtl/clk_freq_meter.sv
// Clock frequency meter: counts rising edges of an asynchronous oscillator
// over a programmable window of reference-clock cycles.
module clk_freq_meter #(
    parameter int WIN_W = 16,
    parameter int CNT_W = 20
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             OSC,
    input  logic             START,
    input  logic [WIN_W-1:0] WIN_LEN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_r;
    logic             osc_meta_r;
    logic             osc_sync_r;
    logic             osc_hist_r;
    logic [WIN_W-1:0] win_cnt_r;
    logic [CNT_W-1:0] edge_cnt_r;
    logic             ovf_r;
    logic             edge_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ovf_nxt_s;

    // OSC synchronizer and edge-history flop, free-running in every state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            osc_meta_r <= 1'b0;
            osc_sync_r <= 1'b0;
            osc_hist_r <= 1'b0;
        end else begin
            osc_meta_r <= OSC;
            osc_sync_r <= osc_meta_r;
            osc_hist_r <= osc_sync_r;
        end
    end

    // Saturating edge count; an edge arriving at full scale flags overflow instead
    always_comb begin
        edge_s    = osc_sync_r & ~osc_hist_r;
        cnt_nxt_s = edge_cnt_r;
        ovf_nxt_s = ovf_r;
        if (edge_s) begin
            if (edge_cnt_r == CNT_MAX) begin
                cnt_nxt_s = edge_cnt_r;
                ovf_nxt_s = 1'b1;
            end else begin
                cnt_nxt_s = edge_cnt_r + CNT_W'(1);
                ovf_nxt_s = ovf_r;
            end
        end else begin
            cnt_nxt_s = edge_cnt_r;
            ovf_nxt_s = ovf_r;
        end
    end

    // Window FSM with registered status and published result
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= IDLE;
            win_cnt_r  <= {WIN_W{1'b0}};
            edge_cnt_r <= {CNT_W{1'b0}};
            ovf_r      <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            COUNT      <= {CNT_W{1'b0}};
            OVF        <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (START) begin
                        if (WIN_LEN != {WIN_W{1'b0}}) begin
                            win_cnt_r  <= WIN_LEN;
                            edge_cnt_r <= {CNT_W{1'b0}};
                            ovf_r      <= 1'b0;
                            BUSY       <= 1'b1;
                            state_r    <= MEAS;
                        end else begin
                            // Empty window publishes a zero result immediately
                            DONE  <= 1'b1;
                            COUNT <= {CNT_W{1'b0}};
                            OVF   <= 1'b0;
                        end
                    end
                end
                MEAS: begin
                    edge_cnt_r <= cnt_nxt_s;
                    ovf_r      <= ovf_nxt_s;
                    win_cnt_r  <= win_cnt_r - WIN_W'(1);
                    if (win_cnt_r == WIN_W'(1)) begin
                        COUNT   <= cnt_nxt_s;
                        OVF     <= ovf_nxt_s;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    BUSY    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Scoreboard bench for clk_freq_meter: a default instance and a 4-bit-count
// instance, with expected results queued at START and popped on DONE.
module tb_clk_freq_meter;

    typedef struct {
        int   cyc;
        int   cnt;
        logic ovf;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        osc_a = 1'b0, osc_b = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] win_a = 16'd0, win_b = 16'd0;
    logic        busy_a, done_a, ovf_a;
    logic        busy_b, done_b, ovf_b;
    logic [19:0] count_a;
    logic [3:0]  count_b;

    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0;
    int   div_a = 4, div_b = 3, ph_a = 0, ph_b = 0;
    logic lvl_b = 1'b0;
    int   busy_lo = 0, busy_hi = -1;
    int   last_count = 0;
    logic last_ovf = 1'b0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t e_a, e_b;

    clk_freq_meter u_dut (
        .CLK(CLK), .RST(RST), .OSC(osc_a), .START(start_a), .WIN_LEN(win_a),
        .BUSY(busy_a), .DONE(done_a), .COUNT(count_a), .OVF(ovf_a)
    );

    clk_freq_meter #(.WIN_W(16), .CNT_W(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .OSC(osc_b), .START(start_b), .WIN_LEN(win_b),
        .BUSY(busy_b), .DONE(done_b), .COUNT(count_b), .OVF(ovf_b)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Oscillators change on the falling edge, away from the sampling edge
    always @(negedge CLK) begin
        ph_a  <= (ph_a + 1 >= div_a) ? 0 : ph_a + 1;
        osc_a <= (ph_a < div_a / 2);
        if (div_b > 0) begin
            ph_b  <= (ph_b + 1 >= div_b) ? 0 : ph_b + 1;
            osc_b <= (ph_b < div_b / 2);
        end else begin
            osc_b <= lvl_b;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor for the default instance: BUSY window, result hold, DONE scoreboard
    always @(negedge CLK) begin
        if (!RST) begin
            check_eq("busy", {31'd0, busy_a}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
            if (done_a) begin
                if (sb_a.size() == 0) begin
                    check_eq("spurious_done", 32'd1, 32'd0);
                end else begin
                    e_a = sb_a.pop_front();
                    check_eq("done_cycle", cyc, e_a.cyc);
                    check_eq("count", {12'd0, count_a}, e_a.cnt);
                    check_eq("ovf", {31'd0, ovf_a}, {31'd0, e_a.ovf});
                    last_count = e_a.cnt;
                    last_ovf   = e_a.ovf;
                end
            end else begin
                check_eq("count_hold", {12'd0, count_a}, last_count);
                check_eq("ovf_hold", {31'd0, ovf_a}, {31'd0, last_ovf});
                if (sb_a.size() > 0 && cyc > sb_a[0].cyc) begin
                    check_eq("missing_done", 32'd0, 32'd1);
                    void'(sb_a.pop_front());
                end
            end
        end
    end

    // Monitor for the 4-bit-count instance
    always @(negedge CLK) begin
        if (!RST) begin
            if (done_b) begin
                if (sb_b.size() == 0) begin
                    check_eq("spurious_done4", 32'd1, 32'd0);
                end else begin
                    e_b = sb_b.pop_front();
                    check_eq("done_cycle4", cyc, e_b.cyc);
                    check_eq("count4", {28'd0, count_b}, e_b.cnt);
                    check_eq("ovf4", {31'd0, ovf_b}, {31'd0, e_b.ovf});
                end
            end else if (sb_b.size() > 0 && cyc > sb_b[0].cyc) begin
                check_eq("missing_done4", 32'd0, 32'd1);
                void'(sb_b.pop_front());
            end
        end
    end

    task automatic start_win(input bit sel_b, input int w, input int exp_cnt, input logic exp_ovf);
        exp_t e;
        @(negedge CLK);
        e.cyc = cyc + 1 + w;
        e.cnt = exp_cnt;
        e.ovf = exp_ovf;
        if (sel_b) begin
            start_b = 1'b1;
            win_b   = w[15:0];
            sb_b.push_back(e);
        end else begin
            start_a = 1'b1;
            win_a   = w[15:0];
            sb_a.push_back(e);
            if (w > 0) begin
                busy_lo = cyc + 1;
                busy_hi = cyc + w;
            end
        end
        @(negedge CLK);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb_a.size() > 0 || sb_b.size() > 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (sb_a.size() > 0 || sb_b.size() > 0) begin
            check_eq("timeout", 32'd0, 32'd1);
            sb_a.delete();
            sb_b.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        repeat (2) @(negedge CLK);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_done", {31'd0, done_a}, 32'd0);
        check_eq("rst_count", {12'd0, count_a}, 32'd0);
        check_eq("rst_ovf", {31'd0, ovf_a}, 32'd0);
        RST = 1'b0;
        repeat (12) @(negedge CLK);

        // CLK/4 over 100 cycles
        start_win(1'b0, 100, 25, 1'b0);
        wait_drain(150);

        // Zero-length window
        start_win(1'b0, 0, 0, 1'b0);
        wait_drain(10);

        // START and WIN_LEN changes ignored mid-window
        start_win(1'b0, 20, 5, 1'b0);
        repeat (4) @(negedge CLK);
        start_a = 1'b1;
        win_a   = 16'd3;
        @(negedge CLK);
        start_a = 1'b0;
        wait_drain(40);

        // Back-to-back: START in the DONE cycle
        start_win(1'b0, 12, 3, 1'b0);
        t = cyc;
        repeat (12) @(negedge CLK);
        check_eq("done_at_restart", {31'd0, done_a}, 32'd1);
        start_a = 1'b1;
        win_a   = 16'd40;
        e_a.cyc = cyc + 41;
        e_a.cnt = 10;
        e_a.ovf = 1'b0;
        sb_a.push_back(e_a);
        busy_lo = cyc + 1;
        busy_hi = cyc + 40;
        @(negedge CLK);
        start_a = 1'b0;
        check_eq("restart_cycle", cyc, t + 13);
        wait_drain(60);

        // Asynchronous reset mid-window: outputs clear before the next edge
        start_win(1'b0, 50, 12, 1'b0);
        repeat (20) @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        check_eq("arst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("arst_done", {31'd0, done_a}, 32'd0);
        check_eq("arst_count", {12'd0, count_a}, 32'd0);
        check_eq("arst_ovf", {31'd0, ovf_a}, 32'd0);
        sb_a.delete();
        busy_lo    = 0;
        busy_hi    = -1;
        last_count = 0;
        last_ovf   = 1'b0;
        #1 RST = 1'b0;
        repeat (60) @(negedge CLK);

        // Recovery window after reset
        start_win(1'b0, 8, 2, 1'b0);
        wait_drain(20);

        // 4-bit count: CLK/3 over 60 cycles saturates, then a flat OSC gives zero
        start_win(1'b1, 60, 15, 1'b1);
        wait_drain(80);
        div_b = 0;
        lvl_b = 1'b1;
        repeat (6) @(negedge CLK);
        start_win(1'b1, 8, 0, 1'b0);
        wait_drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_freq_meter.md
CLK_FREQ_METER -- requirements
Module: clk_freq_meter

Interface
REQ-001 SHALL have parameter WIN_W, default 16: width of the measurement-window length input.
REQ-002 SHALL have parameter CNT_W, default 20: width of the edge-count result.
REQ-003 SHALL have port CLK, input, 1: the single reference clock; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port OSC, input, 1: measured oscillator or inverter-chain clock, asynchronous to CLK.
REQ-006 SHALL have port START, input, 1: one-cycle measurement request.
REQ-007 SHALL have port WIN_LEN, input, WIN_W: window length in CLK cycles.
REQ-008 SHALL have port BUSY, output, 1: high while a window is open.
REQ-009 SHALL have port DONE, output, 1: one-cycle pulse when a result is published.
REQ-010 SHALL have port COUNT, output, CNT_W: OSC rising edges counted in the last window.
REQ-011 SHALL have port OVF, output, 1: the last window's count saturated.

Function
REQ-012 SHALL pass OSC through a two-flop synchronizer, then a third edge-history flop; these run in every state.
REQ-013 SHALL define a rising edge as sync-stage-2 high with history flop low.
REQ-014 SHALL detect an OSC transition 3 CLK edges after it occurs.
REQ-015 SHALL count correctly only when OSC frequency is below CLK/2; behaviour above that is undefined.
REQ-016 SHALL implement two states: IDLE and MEAS.
REQ-017 SHALL, in IDLE with START sampled high at edge t and WIN_LEN nonzero: latch WIN_LEN into the window counter, clear the internal edge counter and overflow flag, and enter MEAS.
REQ-018 SHALL hold MEAS for exactly WIN_LEN cycles, t+1 through t+WIN_LEN.
REQ-019 SHALL drive BUSY high exactly while in MEAS.
REQ-020 SHALL, on each MEAS cycle, increment the edge counter by 1 when an edge is detected, and decrement the window counter.
REQ-021 SHALL saturate the edge counter at 2^CNT_W-1; a further edge sets the internal overflow flag and leaves the count unchanged.
REQ-022 SHALL, in the last MEAS cycle (window counter = 1), include that cycle's edge in the count.
REQ-023 SHALL then copy the count to COUNT and the overflow flag to OVF, pulse DONE during cycle t+WIN_LEN+1, and return to IDLE.
REQ-024 SHALL, for START with WIN_LEN = 0: keep BUSY low, pulse DONE during cycle t+1, and set COUNT = 0 and OVF = 0.
REQ-025 SHALL ignore START while in MEAS, with no restart and no change to the window.
REQ-026 SHALL accept START in the same cycle DONE is high, since the state is then IDLE.
REQ-027 SHALL hold COUNT and OVF stable from DONE until the next DONE.
REQ-028 SHALL NOT alter COUNT or OVF at the start of a new window.
REQ-029 SHALL drive DONE low at all times other than the one-cycle pulse.
REQ-030 SHALL ignore changes to WIN_LEN during MEAS.

Reset
REQ-031 SHALL, while RST is high, immediately and asynchronously force: state IDLE, synchronizer and history flops 0, window counter 0, edge counter 0, BUSY 0, DONE 0, COUNT 0, OVF 0.
REQ-032 SHALL, on RST asserted mid-measurement, abandon the window with no DONE.
REQ-033 SHALL require a new START after RST deasserts before any measurement begins.
REQ-034 SHALL treat the first CLK edge after RST deasserts as a normal IDLE cycle.

Verification
REQ-035 SHALL cover: RST pulsed mid-MEAS between CLK edges -> BUSY/DONE/COUNT/OVF all 0 before the next edge; no DONE follows.
REQ-036 SHALL cover: OSC = CLK/4 free-running for ≥10 cycles, START at t with WIN_LEN = 100 -> BUSY high t+1..t+100, DONE at t+101, COUNT = 25, OVF = 0.
REQ-037 SHALL cover: START with WIN_LEN = 0 -> BUSY never high, DONE at t+1, COUNT = 0, OVF = 0.
REQ-038 SHALL cover: CNT_W = 4, OSC = CLK/3, WIN_LEN = 60 -> DONE at t+61, COUNT = 15, OVF = 1; then a window with OSC held at 1 and WIN_LEN = 8 -> COUNT = 0, OVF = 0.
REQ-039 SHALL cover: START re-pulsed at t+5 during a WIN_LEN = 20 window -> single DONE at t+21.
REQ-040 SHALL cover: START in the DONE cycle -> new window, BUSY high on the next cycle, previous COUNT held until the next DONE.
